// File: rtl/ld_st_unit.sv
// Load/store unit: IDLE -> ACCESS (WAIT_STATES cycles) -> WB over an 8-bit data memory.
// Optional macro LSU_RSVD_REG_CHECK_EN rejects loads targeting registers 14/15 with a one-cycle err pulse.
module ld_st_unit #(
  parameter int WAIT_STATES = 2,
  parameter int DEPTH       = 256
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       is_store,
  input  logic [7:0] addr,
  input  logic [7:0] st_data,
  input  logic [3:0] dst_reg,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       rf_we,
  output logic [3:0] rf_ptr_w,
  output logic [7:0] rf_di
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WB     = 2'd2
  } state_e;

  state_e        r_state;
  state_e        w_state_nxt;
  logic [2:0]    r_cnt;
  logic          r_is_store;
  logic [7:0]    r_addr;
  logic [7:0]    r_st_data;
  logic [3:0]    r_dst_reg;
  logic          w_accept;
  logic          w_rsvd;
  logic [AW-1:0] w_idx;
  logic [7:0]    r_mem [DEPTH];

  // Upper address bits beyond the memory size are dropped, so accesses wrap.
  assign w_idx = AW'(r_addr);

`ifdef LSU_RSVD_REG_CHECK_EN
  logic r_err;

  assign w_rsvd = !is_store && (dst_reg >= 4'd14);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_err <= 1'b0;
    else        r_err <= (r_state == IDLE) && start && w_rsvd;
  end

  assign err = r_err;
`else
  assign w_rsvd = 1'b0;
  assign err    = 1'b0;
`endif

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start && !w_rsvd) begin
          w_accept    = 1'b1;
          w_state_nxt = (WAIT_STATES > 0) ? ACCESS : WB;
        end
      end
      ACCESS:  if (r_cnt == 3'd0) w_state_nxt = WB;
      WB:      w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase

    busy     = (r_state != IDLE);
    done     = (r_state == WB);
    rf_we    = done && !r_is_store;
    rf_ptr_w = rf_we ? r_dst_reg : 4'd0;
    rf_di    = rf_we ? r_mem[w_idx] : 8'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      r_state    <= IDLE;
      r_cnt      <= 3'd0;
      r_is_store <= 1'b0;
      r_addr     <= 8'd0;
      r_st_data  <= 8'd0;
      r_dst_reg  <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_is_store <= is_store;
        r_addr     <= addr;
        r_st_data  <= st_data;
        r_dst_reg  <= dst_reg;
        r_cnt      <= (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;
      end else if ((r_state == ACCESS) && (r_cnt != 3'd0)) begin
        r_cnt <= r_cnt - 3'd1;
      end
    end
  end

  // NOTE: the data memory deliberately has no reset; contents survive rst_n and an
  // aborted store cannot write because reset has already forced the FSM out of WB.
  always_ff @(posedge clk) begin
    if ((r_state == WB) && r_is_store) r_mem[w_idx] <= r_st_data;
  end

endmodule

// File: tb/tb_ld_st_unit.sv
// Self-checking bench for ld_st_unit: two instances (WAIT_STATES=2/DEPTH=256 and
// WAIT_STATES=0/DEPTH=16) against a transaction-level model, plus literal directed checks.
module tb_ld_st_unit;

`ifdef LSU_RSVD_REG_CHECK_EN
  localparam bit RSVD = 1'b1;
`else
  localparam bit RSVD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start = 1'b0;
  logic       is_store = 1'b0;
  logic [7:0] addr = 8'd0;
  logic [7:0] st_data = 8'd0;
  logic [3:0] dst_reg = 4'd0;

  wire  [1:0] d_busy, d_done, d_err, d_we;
  wire  [3:0] d_ptr [2];
  wire  [7:0] d_di  [2];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ld_st_unit #(.WAIT_STATES(2), .DEPTH(256)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .is_store(is_store), .addr(addr),
    .st_data(st_data), .dst_reg(dst_reg), .busy(d_busy[0]), .done(d_done[0]),
    .err(d_err[0]), .rf_we(d_we[0]), .rf_ptr_w(d_ptr[0]), .rf_di(d_di[0])
  );

  ld_st_unit #(.WAIT_STATES(0), .DEPTH(16)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .is_store(is_store), .addr(addr),
    .st_data(st_data), .dst_reg(dst_reg), .busy(d_busy[1]), .done(d_done[1]),
    .err(d_err[1]), .rf_we(d_we[1]), .rf_ptr_w(d_ptr[1]), .rf_di(d_di[1])
  );

  // Transaction-level model: one optional in-flight request per instance, tagged with
  // the absolute cycle in which its write-back happens.
  int         cyc = 0;
  bit         m_act    [2];
  int         m_wb_at  [2];
  int         m_err_at [2];
  bit         m_st     [2];
  logic [7:0] m_addr   [2];
  logic [7:0] m_data   [2];
  logic [3:0] m_dst    [2];
  logic [7:0] m_mem    [2][256];

  function automatic int ws_of(input int k);
    return (k == 0) ? 2 : 0;
  endfunction

  function automatic int depth_of(input int k);
    return (k == 0) ? 256 : 16;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        for (int k = 0; k < 2; k++) begin
          m_act[k]    = 1'b0;
          m_err_at[k] = -1;
        end
      end else begin
        for (int k = 0; k < 2; k++) begin
          bit was_busy;
          was_busy = m_act[k];
          if (m_act[k] && (cyc == m_wb_at[k])) begin
            if (m_st[k]) m_mem[k][int'(m_addr[k]) % depth_of(k)] = m_data[k];
            m_act[k] = 1'b0;
          end
          if (!was_busy && start) begin
            if (RSVD && !is_store && (dst_reg >= 4'd14)) begin
              m_err_at[k] = cyc + 1;
            end else begin
              m_act[k]   = 1'b1;
              m_wb_at[k] = cyc + ws_of(k) + 1;
              m_st[k]    = is_store;
              m_addr[k]  = addr;
              m_data[k]  = st_data;
              m_dst[k]   = dst_reg;
            end
          end
        end
        cyc++;
      end
    end
  end

  // Compare every DUT output against the model on each falling edge.
  initial begin
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        bit         e_done, e_we;
        logic [3:0] e_ptr;
        logic [7:0] e_di;
        e_done = m_act[k] && (cyc == m_wb_at[k]);
        e_we   = e_done && !m_st[k];
        e_ptr  = e_we ? m_dst[k] : 4'd0;
        e_di   = e_we ? m_mem[k][int'(m_addr[k]) % depth_of(k)] : 8'd0;
        check($sformatf("busy%0d", k), 32'(d_busy[k]), 32'(m_act[k]));
        check($sformatf("done%0d", k), 32'(d_done[k]), 32'(e_done));
        check($sformatf("err%0d", k),  32'(d_err[k]),  32'(cyc == m_err_at[k]));
        check($sformatf("rf_we%0d", k), 32'(d_we[k]), 32'(e_we));
        if (!(e_done && m_st[k])) begin
          check($sformatf("rf_ptr_w%0d", k), 32'(d_ptr[k]), 32'(e_ptr));
          check($sformatf("rf_di%0d", k),    32'(d_di[k]),  32'(e_di));
        end
      end
    end
  end

  // Per-transaction trace: bit i of each mask is the value in cycle i after the start edge.
  logic [6:0] t_busy [2];
  logic [6:0] t_done [2];
  logic [6:0] t_err  [2];
  bit         t_we   [2];
  logic [3:0] t_ptr  [2];
  logic [7:0] t_di   [2];

  // Issues one request at edge 0, then during cycle i drives extra start pulses
  // (stores of 0xFF to the same address) where extra[i] is set. Ends at edge 6 + 2.
  task automatic txn(input bit st, input logic [7:0] a, input logic [7:0] d,
                     input logic [3:0] r, input logic [6:0] extra);
    is_store = st; addr = a; st_data = d; dst_reg = r; start = 1'b1;
    @(posedge clk); #2;
    for (int k = 0; k < 2; k++) begin
      t_busy[k] = '0; t_done[k] = '0; t_err[k] = '0;
      t_we[k] = 1'b0; t_ptr[k] = '0; t_di[k] = '0;
    end
    for (int i = 1; i <= 6; i++) begin
      start = extra[i];
      if (extra[i]) begin
        is_store = 1'b1; st_data = 8'hFF; dst_reg = 4'd9;
      end
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        t_busy[k][i] = d_busy[k];
        t_done[k][i] = d_done[k];
        t_err[k][i]  = d_err[k];
        if (d_we[k]) begin
          t_we[k] = 1'b1; t_ptr[k] = d_ptr[k]; t_di[k] = d_di[k];
        end
      end
      @(posedge clk); #2;
    end
    start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    // Fill memory with a known pattern: mem[a] = a ^ 0x5C.
    for (int a = 0; a < 256; a++) begin
      is_store = 1'b1; addr = 8'(a); st_data = 8'(a) ^ 8'h5C; start = 1'b1;
      @(posedge clk); #2;
      start = 1'b0;
      repeat (3) begin
        @(posedge clk); #2;
      end
    end

    // Store timing on the two-wait-state instance.
    txn(1'b1, 8'h10, 8'hA5, 4'd0, 7'b0);
    check("st_busy_trace", 32'(t_busy[0][4:1]), 32'h7);
    check("st_done_trace", 32'(t_done[0][6:1]), 32'h04);
    check("st_rf_we",      32'(t_we[0]), 32'h0);

    // Load back the stored value.
    txn(1'b0, 8'h10, 8'h00, 4'd3, 7'b0);
    check("ld_done_trace", 32'(t_done[0][6:1]), 32'h04);
    check("ld_busy_trace", 32'(t_busy[0][4:1]), 32'h7);
    check("ld_rf_we",      32'(t_we[0]), 32'h1);
    check("ld_rf_ptr_w",   32'(t_ptr[0]), 32'h3);
    check("ld_rf_di",      32'(t_di[0]), 32'hA5);

    // Starts while busy are ignored.
    txn(1'b0, 8'h10, 8'h00, 4'd5, 7'b0000110);
    check("ign_done_trace", 32'(t_done[0][6:1]), 32'h04);
    check("ign_rf_ptr_w",   32'(t_ptr[0]), 32'h5);
    check("ign_rf_di",      32'(t_di[0]), 32'hA5);
    txn(1'b0, 8'h10, 8'h00, 4'd2, 7'b0);
    check("ign_mem_kept", 32'(t_di[0]), 32'hA5);

    // Zero wait states: WB in cycle 1, next start at edge 2 finishes in cycle 3.
    txn(1'b0, 8'h30, 8'h00, 4'd7, 7'b0000100);
    check("ws0_done_trace", 32'(t_done[1][6:1]), 32'h05);
    check("ws0_busy_trace", 32'(t_busy[1][3:1]), 32'h5);
    check("ws2_ign_edge2",  32'(t_done[0][6:1]), 32'h04);

    // Address wrap on the 16-entry instance.
    txn(1'b1, 8'h03, 8'h77, 4'd0, 7'b0);
    txn(1'b0, 8'h13, 8'h00, 4'd6, 7'b0);
    check("wrap_d16_rf_di",  32'(t_di[1]), 32'h77);
    check("wrap_d256_rf_di", 32'(t_di[0]), 32'h4F);

    // Reserved destination register.
    txn(1'b0, 8'h40, 8'h00, 4'd15, 7'b0);
    if (RSVD) begin
      check("rsvd_err_trace",  32'(t_err[0][6:1]), 32'h01);
      check("rsvd_busy_trace", 32'(t_busy[0][6:1]), 32'h00);
      check("rsvd_done_trace", 32'(t_done[0][6:1]), 32'h00);
      check("rsvd_rf_we",      32'(t_we[0]), 32'h0);
    end else begin
      check("rsvd_done_trace", 32'(t_done[0][6:1]), 32'h04);
      check("rsvd_rf_we",      32'(t_we[0]), 32'h1);
      check("rsvd_rf_ptr_w",   32'(t_ptr[0]), 32'hF);
      check("rsvd_rf_di",      32'(t_di[0]), 32'h1C);
    end

    // Reset during ACCESS aborts the store; memory keeps its old value.
    txn(1'b1, 8'h20, 8'h33, 4'd0, 7'b0);
    is_store = 1'b1; addr = 8'h20; st_data = 8'h5A; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("rst_busy",     32'(d_busy[0]), 32'h0);
    check("rst_done",     32'(d_done[0]), 32'h0);
    check("rst_err",      32'(d_err[0]),  32'h0);
    check("rst_rf_we",    32'(d_we[0]),   32'h0);
    check("rst_rf_ptr_w", 32'(d_ptr[0]),  32'h0);
    check("rst_rf_di",    32'(d_di[0]),   32'h0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    txn(1'b0, 8'h20, 8'h00, 4'd4, 7'b0);
    check("rst_abort_rf_di",    32'(t_di[0]),  32'h33);
    check("rst_abort_rf_ptr_w", 32'(t_ptr[0]), 32'h4);

    // Randomized traffic with occasional mid-cycle resets.
    for (int n = 0; n < 3000; n++) begin
      start    = ($urandom_range(0, 2) == 0);
      is_store = $urandom_range(0, 1) == 1;
      addr     = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 7)) : 8'($urandom);
      st_data  = 8'($urandom);
      dst_reg  = 4'($urandom);
      if ($urandom_range(0, 299) == 0) begin
        #1 rst_n = 1'b0;
        #3 rst_n = 1'b1;
      end
      @(posedge clk); #2;
    end
    start = 1'b0;
    repeat (6) begin
      @(posedge clk); #2;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
